rv_fetch_resp: RTL and testbench

- Instruction-side responder paired with the core's PC generator (rv_fetch).
- Takes the word PC that fetch presents and turns it into single-outstanding read requests on a simple req/ack instruction bus.
- Buffers the returned words with their PCs in a small FIFO and hands them to decode with a valid/ready handshake.
- Drives the stall back to fetch and discards wrong-path data on a redirect.

---
 rtl/rv_fetch_resp.sv | 180 ++++++++++++++++++
 tb/tb_rv_fetch_resp.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_fetch_resp.sv
// Instruction-side responder: turns fetch PCs into single-outstanding bus reads and queues results for decode.
// Optional same-cycle bypass of an empty queue is enabled by defining RV_FETCH_RESP_BYPASS_EN.
module rv_fetch_resp #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          BUF_DEPTH  = 2
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [29:0] i_pc,
    input  logic        i_flush,
    output logic        o_stall,
    output logic        o_bus_req,
    output logic [29:0] o_bus_addr,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata,
    output logic        o_instr_valid,
    output logic [31:0] o_instr,
    output logic [29:0] o_instr_pc,
    input  logic        i_instr_ready
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW:0]   DEPTH_CMP = (CW + 1)'(BUF_DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]    state_r;
    logic          bus_req_r;
    logic [29:0]   bus_addr_r;
    logic [CW-1:0] cnt_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [31:0]   mem_instr_r [BUF_DEPTH];
    logic [29:0]   mem_pc_r    [BUF_DEPTH];
    logic          instr_valid_r;
    logic [31:0]   instr_r;
    logic [29:0]   instr_pc_r;

    logic          busy_s;
    logic [CW:0]   occ_s;
    logic          room_s;
    logic          ack_live_s;
    logic          launch_s;
    logic          bypass_s;
    logic          push_s;
    logic          pop_s;
    logic [CW-1:0] cnt_n_s;
    logic [PW-1:0] rd_ptr_n_s;
    logic [PW-1:0] wr_ptr_n_s;
    logic [31:0]   head_instr_s;
    logic [29:0]   head_pc_s;
    logic          load_head_s;

    // Occupancy counts the in-flight kept request so a returning word always has a slot.
    assign busy_s     = (state_r == ST_BUSY);
    assign occ_s      = {1'b0, cnt_r} + {{CW{1'b0}}, busy_s};
    assign room_s     = (occ_s < DEPTH_CMP);
    assign ack_live_s = (state_r != ST_IDLE) & i_bus_ack;
    assign launch_s   = room_s & ~i_flush & ((state_r == ST_IDLE) | ack_live_s);
    assign o_stall    = ~launch_s & ~i_flush;

`ifdef RV_FETCH_RESP_BYPASS_EN
    assign bypass_s = (cnt_r == {CW{1'b0}}) & busy_s & i_bus_ack & i_instr_ready & ~i_flush;
`else
    assign bypass_s = 1'b0;
`endif

    assign push_s = busy_s & i_bus_ack & ~i_flush & ~bypass_s;
    assign pop_s  = instr_valid_r & i_instr_ready & ~i_flush;

    // Next queue pointers and occupancy; a flush empties everything.
    always_comb begin
        cnt_n_s    = cnt_r;
        rd_ptr_n_s = rd_ptr_r;
        wr_ptr_n_s = wr_ptr_r;
        if (i_flush) begin
            cnt_n_s    = {CW{1'b0}};
            rd_ptr_n_s = {PW{1'b0}};
            wr_ptr_n_s = {PW{1'b0}};
        end else begin
            if (pop_s) begin
                rd_ptr_n_s = rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_n_s = rd_ptr_r;
            end
            if (push_s) begin
                wr_ptr_n_s = wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_n_s = wr_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_n_s = cnt_r + CNT_ONE;
                2'b01:   cnt_n_s = cnt_r - CNT_ONE;
                default: cnt_n_s = cnt_r;
            endcase
        end
    end

    // Next head entry; the word arriving this cycle is forwarded when it lands at the new head slot.
    always_comb begin
        head_instr_s = mem_instr_r[rd_ptr_n_s];
        head_pc_s    = mem_pc_r[rd_ptr_n_s];
        if ((push_s | bypass_s) && (wr_ptr_r == rd_ptr_n_s)) begin
            head_instr_s = i_bus_rdata;
            head_pc_s    = bus_addr_r;
        end else begin
            head_instr_s = mem_instr_r[rd_ptr_n_s];
            head_pc_s    = mem_pc_r[rd_ptr_n_s];
        end
    end

    assign load_head_s = (cnt_n_s != {CW{1'b0}}) | bypass_s;

    // Bus request state: launch, completion and flush-to-drop handling.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r    <= ST_IDLE;
            bus_req_r  <= 1'b0;
            bus_addr_r <= RESET_ADDR[31:2];
        end else if (i_flush) begin
            if ((state_r != ST_IDLE) && !i_bus_ack) begin
                state_r   <= ST_DROP;
                bus_req_r <= 1'b1;
            end else begin
                state_r   <= ST_IDLE;
                bus_req_r <= 1'b0;
            end
        end else if (launch_s) begin
            state_r    <= ST_BUSY;
            bus_req_r  <= 1'b1;
            bus_addr_r <= i_pc;
        end else if (ack_live_s) begin
            state_r   <= ST_IDLE;
            bus_req_r <= 1'b0;
        end else begin
            state_r   <= state_r;
            bus_req_r <= bus_req_r;
        end
    end

    // Instruction queue storage and registered head outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_r         <= {CW{1'b0}};
            rd_ptr_r      <= {PW{1'b0}};
            wr_ptr_r      <= {PW{1'b0}};
            instr_valid_r <= 1'b0;
            instr_r       <= 32'h0000_0000;
            instr_pc_r    <= 30'h0000_0000;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_instr_r[i] <= 32'h0000_0000;
                mem_pc_r[i]    <= 30'h0000_0000;
            end
        end else begin
            cnt_r         <= cnt_n_s;
            rd_ptr_r      <= rd_ptr_n_s;
            wr_ptr_r      <= wr_ptr_n_s;
            instr_valid_r <= (cnt_n_s != {CW{1'b0}});
            if (push_s) begin
                mem_instr_r[wr_ptr_r] <= i_bus_rdata;
                mem_pc_r[wr_ptr_r]    <= bus_addr_r;
            end
            if (load_head_s) begin
                instr_r    <= head_instr_s;
                instr_pc_r <= head_pc_s;
            end
        end
    end

    assign o_bus_req     = bus_req_r;
    assign o_bus_addr    = bus_addr_r;
    assign o_instr_valid = instr_valid_r | bypass_s;
    assign o_instr       = bypass_s ? i_bus_rdata : instr_r;
    assign o_instr_pc    = bypass_s ? bus_addr_r : instr_pc_r;

endmodule

// File: tb/tb_rv_fetch_resp.sv
// Self-checking bench for rv_fetch_resp: queue-based reference model, directed scenarios and random traffic.
module tb_rv_fetch_resp;
    localparam int          D  = 2;
    localparam logic [31:0] RA = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        i_reset_n;
    logic [29:0] i_pc;
    logic        i_flush;
    logic        o_stall;
    logic        o_bus_req;
    logic [29:0] o_bus_addr;
    logic        i_bus_ack;
    logic [31:0] i_bus_rdata;
    logic        o_instr_valid;
    logic [31:0] o_instr;
    logic [29:0] o_instr_pc;
    logic        i_instr_ready;

    always #5 clk = ~clk;

    rv_fetch_resp #(.RESET_ADDR(RA), .BUF_DEPTH(D)) dut (
        .i_clk(clk), .i_reset_n(i_reset_n), .i_pc(i_pc), .i_flush(i_flush),
        .o_stall(o_stall), .o_bus_req(o_bus_req), .o_bus_addr(o_bus_addr),
        .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata),
        .o_instr_valid(o_instr_valid), .o_instr(o_instr), .o_instr_pc(o_instr_pc),
        .i_instr_ready(i_instr_ready)
    );

    typedef struct packed { logic [29:0] pc; logic [31:0] instr; } ent_t;

    int total = 0;
    int bad   = 0;

    // Reference model: queued words, kind of outstanding request (0 none, 1 kept, 2 dropped), its address.
    ent_t        q[$];
    ent_t        last;
    int          m_out;
    logic [29:0] m_addr;
    logic [29:0] fetch_pc;
    logic [29:0] req_log[$];
    logic [29:0] dlv_log[$];
    logic        prev_req, prev_ack;
    logic        last_stall, launched, ack_stall_any;
    logic [31:0] seen_instr;
    int          wait_cnt, cur_lat;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        last     = '0;
        m_out    = 0;
        m_addr   = RA[31:2];
        prev_req = 1'b0;
        prev_ack = 1'b0;
        req_log.delete();
        dlv_log.delete();
        wait_cnt = 0;
        cur_lat  = 1;
    endtask

    // Called at posedge+1; drives inputs, checks at negedge, advances the model, returns at next posedge+1.
    task automatic cycle(input logic fl, input logic [29:0] tgt, input logic ak,
                         input logic [31:0] rd, input logic rdy);
        logic room, launch, es, byp, ev, pop, push;
        ent_t head;
        i_pc = fetch_pc; i_flush = fl; i_bus_ack = ak; i_bus_rdata = rd; i_instr_ready = rdy;
        @(negedge clk);
        room   = (q.size() + ((m_out == 1) ? 1 : 0)) < D;
        launch = room && !fl && (m_out == 0 || ak);
        es     = !launch && !fl;
        byp    = 1'b0;
`ifdef RV_FETCH_RESP_BYPASS_EN
        byp = (q.size() == 0) && (m_out == 1) && ak && rdy && !fl;
`endif
        if (byp) begin
            head.pc = m_addr; head.instr = rd;
        end else if (q.size() > 0) begin
            head = q[0];
        end else begin
            head = last;
        end
        ev = (q.size() > 0) || byp;
        chk("stall",    64'(o_stall),       64'(es));
        chk("bus_req",  64'(o_bus_req),     64'(m_out != 0));
        chk("bus_addr", 64'(o_bus_addr),    64'(m_addr));
        chk("valid",    64'(o_instr_valid), 64'(ev));
        chk("instr",    64'(o_instr),       64'(head.instr));
        chk("instr_pc", 64'(o_instr_pc),    64'(head.pc));
        last_stall = o_stall;
        seen_instr = o_instr;
        if (ak && o_stall) ack_stall_any = 1'b1;
        if (o_bus_req && (!prev_req || prev_ack)) req_log.push_back(o_bus_addr);
        prev_req = o_bus_req;
        prev_ack = ak;
        if (o_instr_valid && rdy && !fl) dlv_log.push_back(o_instr_pc);
        pop  = (q.size() > 0) && rdy && !fl;
        push = ak && (m_out == 1) && !fl && !byp;
        if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                ent_t e;
                e.pc = m_addr; e.instr = rd;
                q.push_back(e);
            end
        end
        if (byp) last = head;
        if (q.size() > 0) last = q[0];
        if (fl) m_out = (m_out != 0 && !ak) ? 2 : 0;
        else if (launch) begin m_out = 1; m_addr = fetch_pc; end
        else if (m_out != 0 && ak) m_out = 0;
        launched = launch;
        if (fl) fetch_pc = tgt;
        else if (!es) fetch_pc = fetch_pc + 30'd1;
        @(posedge clk);
        #1;
    endtask

    // Bus answers each request after a fixed (lat >= 0) or random latency; ready: 0, 1 or random.
    task automatic run(input int n, input int lat, input int rmode, input bit fl_en);
        logic ak, rdy, fl;
        for (int i = 0; i < n; i++) begin
            ak  = (m_out != 0) && (wait_cnt >= cur_lat);
            rdy = (rmode == 2) ? 1'($urandom_range(0, 1)) : (rmode == 1);
            fl  = fl_en && ($urandom_range(0, 15) == 0);
            cycle(fl, 30'($urandom), ak, $urandom, rdy);
            if (launched) begin
                wait_cnt = 0;
                cur_lat  = (lat >= 0) ? lat : $urandom_range(0, 3);
            end else if (m_out != 0) begin
                wait_cnt++;
            end
        end
    endtask

    task automatic do_reset(input logic [29:0] start_pc);
        i_reset_n = 1'b0;
        i_flush = 1'b0; i_bus_ack = 1'b0; i_bus_rdata = 32'h0; i_instr_ready = 1'b0;
        fetch_pc = start_pc;
        i_pc = start_pc;
        model_reset();
        @(posedge clk); #1;
        chk("rst_req",   64'(o_bus_req),     64'(0));
        chk("rst_addr",  64'(o_bus_addr),    64'(30'h40));
        chk("rst_valid", 64'(o_instr_valid), 64'(0));
        chk("rst_instr", 64'(o_instr),       64'(0));
        chk("rst_pc",    64'(o_instr_pc),    64'(0));
        chk("rst_stall", 64'(o_stall),       64'(0));
        @(posedge clk); #1;
        i_reset_n = 1'b1;
    endtask

    function automatic int count_of(input logic [29:0] v);
        int c = 0;
        foreach (dlv_log[k]) if (dlv_log[k] == v) c++;
        return c;
    endfunction

    initial begin
        // In-order streaming with one wait cycle per request.
        do_reset(30'h40);
        ack_stall_any = 1'b0;
        run(14, 1, 1, 1'b0);
        chk("t1_req0", 64'(req_log[0]), 64'(30'h40));
        chk("t1_req1", 64'(req_log[1]), 64'(30'h41));
        chk("t1_req2", 64'(req_log[2]), 64'(30'h42));
        chk("t1_dlv0", 64'(dlv_log[0]), 64'(30'h40));
        chk("t1_dlv2", 64'(dlv_log[2]), 64'(30'h42));
        chk("t1_ack_stall", 64'(ack_stall_any), 64'(0));

        // Backpressure fills the queue, then drains.
        do_reset(30'h10);
        run(7, 1, 0, 1'b0);
        chk("t2_stall", 64'(last_stall), 64'(1));
        chk("t2_req",   64'(o_bus_req),  64'(0));
        chk("t2_pc",    64'(fetch_pc),   64'(30'h12));
        run(6, 1, 1, 1'b0);
        chk("t2_dlv0", 64'(dlv_log[0]), 64'(30'h10));
        chk("t2_dlv1", 64'(dlv_log[1]), 64'(30'h11));
        chk("t2_req2", 64'(req_log[2]), 64'(30'h12));

        // Flush while a request is outstanding; its late ack is dropped.
        do_reset(30'h20);
        cycle(1'b0, 30'h0, 1'b0, 32'h1111_1111, 1'b1);
        cycle(1'b0, 30'h0, 1'b0, 32'h1111_1111, 1'b1);
        cycle(1'b1, 30'h80, 1'b0, 32'h1111_1111, 1'b1);
        chk("t3_flush_stall", 64'(last_stall), 64'(0));
        cycle(1'b0, 30'h0, 1'b0, 32'h1111_1111, 1'b1);
        cycle(1'b0, 30'h0, 1'b0, 32'h1111_1111, 1'b1);
        cycle(1'b0, 30'h0, 1'b1, 32'h2020_2020, 1'b1);
        cycle(1'b0, 30'h0, 1'b0, 32'h3333_3333, 1'b1);
        chk("t3_req_n",  64'(req_log.size()), 64'(2));
        chk("t3_req80",  64'(req_log[1]),     64'(30'h80));
        cycle(1'b0, 30'h0, 1'b1, 32'h8080_8080, 1'b1);
        cycle(1'b0, 30'h0, 1'b0, 32'h3333_3333, 1'b1);
        chk("t3_no20",  64'(count_of(30'h20)), 64'(0));
        chk("t3_dlv80", 64'(dlv_log[0]),       64'(30'h80));
        chk("t3_instr", 64'(seen_instr),       64'(32'h8080_8080));

        // Flush coinciding with a pop from a full queue.
        do_reset(30'h10);
        run(7, 1, 0, 1'b0);
        chk("t4_full", 64'(o_instr_valid), 64'(1));
        cycle(1'b1, 30'h200, 1'b0, 32'h0, 1'b1);
        chk("t4_empty", 64'(o_instr_valid), 64'(0));
        run(8, 1, 1, 1'b0);
        chk("t4_no10",  64'(count_of(30'h10)), 64'(0));
        chk("t4_no11",  64'(count_of(30'h11)), 64'(0));
        chk("t4_dlv0",  64'(dlv_log[0]),       64'(30'h200));

        // Slow bus: request held steady until the ack.
        do_reset(30'h30);
        cycle(1'b0, 30'h0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 30'h0, 1'b0, 32'h0, 1'b1);
            chk("t5_stall", 64'(last_stall), 64'(1));
            chk("t5_req",   64'(o_bus_req),  64'(1));
            chk("t5_addr",  64'(o_bus_addr), 64'(30'h30));
        end
        cycle(1'b0, 30'h0, 1'b1, 32'h0000_0093, 1'b1);
        chk("t5_ack_stall", 64'(last_stall), 64'(0));

        // Asynchronous reset in the middle of a request, then a stale ack.
        do_reset(30'h40);
        cycle(1'b0, 30'h0, 1'b0, 32'h0, 1'b1);
        chk("t6_req_up", 64'(o_bus_req), 64'(1));
        #2;
        i_reset_n = 1'b0;
        #1;
        chk("t6_async_req",  64'(o_bus_req),  64'(0));
        chk("t6_async_addr", 64'(o_bus_addr), 64'(30'h40));
        model_reset();
        fetch_pc = 30'h40;
        @(posedge clk); #1;
        i_reset_n = 1'b1;
        cycle(1'b0, 30'h0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        cycle(1'b0, 30'h0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 30'h0, 1'b0, 32'h0, 1'b1);
        chk("t6_late_ack", 64'(o_instr_valid), 64'(0));
        chk("t6_no_dlv",   64'(dlv_log.size()), 64'(0));
`ifdef RV_FETCH_RESP_BYPASS_EN
        cycle(1'b0, 30'h0, 1'b1, 32'h0000_0013, 1'b1);
        chk("t6_bypass", 64'(seen_instr), 64'(32'h0000_0013));
`endif

        // Random traffic: random latency, ready and flushes.
        do_reset(30'($urandom));
        run(3000, -1, 2, 1'b1);
        do_reset(30'($urandom));
        run(1500, -1, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
